// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with run-enable,
// registered sync/de/coordinate outputs and line/frame/vblank strobes.
// Optional frame counter built only when VGA_FRAME_CNT_EN is defined;
// otherwise frame_cnt is tied to zero.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          HSYNC_POL   = 1'b0,
    parameter bit          VSYNC_POL   = 1'b0,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned CNT_W       = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] px_x,
    output logic [CNT_W-1:0] px_y,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank_start,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] h_cnt_q, v_cnt_q;
    logic [CNT_W-1:0] h_cnt_d, v_cnt_d;

    logic             hsync_q, vsync_q, de_q;
    logic [CNT_W-1:0] px_x_q, px_y_q;
    logic             line_start_q, frame_start_q, vblank_start_q;

    logic             hsync_d, vsync_d, de_d;
    logic [CNT_W-1:0] px_x_d, px_y_d;
    logic             line_start_d, frame_start_d, vblank_start_d;
    logic             run;

    // Next counter position and output decode of the current position
    always_comb begin
        run     = (state_q == RUN);
        h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
        end

        hsync_d = (run && h_cnt_q >= H_SYNC_S && h_cnt_q < H_SYNC_E) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = (run && v_cnt_q >= V_SYNC_S && v_cnt_q < V_SYNC_E) ? VSYNC_POL : ~VSYNC_POL;
        de_d    = run && (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        px_x_d  = run ? (h_cnt_q >> SCALE_SHIFT) : '0;
        px_y_d  = run ? (v_cnt_q >> SCALE_SHIFT) : '0;

        line_start_d   = run && (h_cnt_q == '0);
        frame_start_d  = line_start_d && (v_cnt_q == '0);
        vblank_start_d = line_start_d && (v_cnt_q == V_VIS);
    end

    // Run/idle FSM, raster counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            h_cnt_q        <= '0;
            v_cnt_q        <= '0;
            hsync_q        <= ~HSYNC_POL;
            vsync_q        <= ~VSYNC_POL;
            de_q           <= 1'b0;
            px_x_q         <= '0;
            px_y_q         <= '0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            de_q           <= de_d;
            px_x_q         <= px_x_d;
            px_y_q         <= px_y_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        // Dropping en is a stop, not a pause: next run starts at frame top
                        state_q <= IDLE;
                        h_cnt_q <= '0;
                        v_cnt_q <= '0;
                    end else begin
                        h_cnt_q <= h_cnt_d;
                        v_cnt_q <= v_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign de           = de_q;
    assign px_x         = px_x_q;
    assign px_y         = px_y_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    logic        first_q;

    // Frame counter: skips the frame_start that opens each run
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt_q <= '0;
            first_q     <= 1'b0;
        end else if (state_q == IDLE && en) begin
            first_q <= 1'b1;
        end else if (frame_start_d) begin
            if (first_q) begin
                first_q <= 1'b0;
            end else begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default-parameter instance and a small
// override instance (active-high syncs, no scaling) share clk/rst/en.
// Expected outputs are queued per stimulus cycle and checked by a monitor;
// a few hand-computed timing measurements are checked at the end.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [15:0] x;
        logic [15:0] y;
        logic        ls;
        logic        fs;
        logic        vb;
        logic [15:0] fc;
    } exp_t;

    // instance 0: defaults; instance 1: 8/2/3/1 x 6/1/2/1, pol 1, shift 0
    localparam int unsigned HV[2] = '{640, 8};
    localparam int unsigned HF[2] = '{16, 2};
    localparam int unsigned HS[2] = '{96, 3};
    localparam int unsigned HB[2] = '{48, 1};
    localparam int unsigned VV[2] = '{480, 6};
    localparam int unsigned VF[2] = '{10, 1};
    localparam int unsigned VS[2] = '{2, 2};
    localparam int unsigned VB[2] = '{33, 1};
    localparam bit          HP[2] = '{1'b0, 1'b1};
    localparam bit          VP[2] = '{1'b0, 1'b1};
    localparam int unsigned SH[2] = '{1, 0};

`ifdef VGA_FRAME_CNT_EN
    localparam bit FC_ON = 1'b1;
`else
    localparam bit FC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;

    logic        d0_hs, d0_vs, d0_de, d0_ls, d0_fs, d0_vb;
    logic [10:0] d0_x, d0_y;
    logic [15:0] d0_fc;
    logic        d1_hs, d1_vs, d1_de, d1_ls, d1_fs, d1_vb;
    logic [7:0]  d1_x, d1_y;
    logic [15:0] d1_fc;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t q0[$];
    exp_t q1[$];

    bit          m_run[2];
    int unsigned m_t[2];
    bit          m_first[2];
    logic [15:0] m_fc[2];

    always #5 clk = ~clk;

    vga_timing_gen u_dut0 (
        .clk(clk), .rst(rst), .en(en),
        .hsync(d0_hs), .vsync(d0_vs), .de(d0_de),
        .px_x(d0_x), .px_y(d0_y),
        .line_start(d0_ls), .frame_start(d0_fs), .vblank_start(d0_vb),
        .frame_cnt(d0_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .SCALE_SHIFT(0), .CNT_W(8)
    ) u_dut1 (
        .clk(clk), .rst(rst), .en(en),
        .hsync(d1_hs), .vsync(d1_vs), .de(d1_de),
        .px_x(d1_x), .px_y(d1_y),
        .line_start(d1_ls), .frame_start(d1_fs), .vblank_start(d1_vb),
        .frame_cnt(d1_fc)
    );

    function automatic void check(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endfunction

    function automatic exp_t idle_out(input int i);
        exp_t e;
        e    = '0;
        e.hs = ~HP[i];
        e.vs = ~VP[i];
        return e;
    endfunction

    // Position derived from absolute run time rather than nested counters
    function automatic exp_t run_out(input int i, input int unsigned t);
        exp_t        e;
        int unsigned ht, h, v;
        ht   = HV[i] + HF[i] + HS[i] + HB[i];
        h    = t % ht;
        v    = t / ht;
        e    = '0;
        e.hs = (h >= HV[i] + HF[i] && h < HV[i] + HF[i] + HS[i]) ? HP[i] : ~HP[i];
        e.vs = (v >= VV[i] + VF[i] && v < VV[i] + VF[i] + VS[i]) ? VP[i] : ~VP[i];
        e.de = (h < HV[i]) && (v < VV[i]);
        e.x  = 16'(h >> SH[i]);
        e.y  = 16'(v >> SH[i]);
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        e.vb = (h == 0) && (v == VV[i]);
        return e;
    endfunction

    task automatic step(input bit r, input bit e_in);
        @(negedge clk);
        rst = r;
        en  = e_in;
        for (int i = 0; i < 2; i++) begin
            exp_t        x;
            int unsigned ft;
            ft = (HV[i] + HF[i] + HS[i] + HB[i]) * (VV[i] + VF[i] + VS[i] + VB[i]);
            if (!r) begin
                x          = idle_out(i);
                m_run[i]   = 1'b0;
                m_t[i]     = 0;
                m_first[i] = 1'b0;
                m_fc[i]    = '0;
            end else begin
                if (m_run[i]) begin
                    x = run_out(i, m_t[i]);
                    if (x.fs) begin
                        if (m_first[i]) m_first[i] = 1'b0;
                        else m_fc[i] = m_fc[i] + 16'd1;
                    end
                end else begin
                    x = idle_out(i);
                end
                if (!m_run[i]) begin
                    if (e_in) begin
                        m_run[i]   = 1'b1;
                        m_t[i]     = 0;
                        m_first[i] = 1'b1;
                    end
                end else if (!e_in) begin
                    m_run[i] = 1'b0;
                    m_t[i]   = 0;
                end else begin
                    m_t[i] = (m_t[i] + 1) % ft;
                end
            end
            x.fc = FC_ON ? m_fc[i] : 16'd0;
            if (i == 0) q0.push_back(x);
            else q1.push_back(x);
        end
    endtask

    // Scoreboard monitor: compare each registered output set against the queue
    always @(posedge clk) begin
        exp_t e, a;
        #2;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = {d0_hs, d0_vs, d0_de, 16'(d0_x), 16'(d0_y), d0_ls, d0_fs, d0_vb, d0_fc};
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL sb_default @%0t: got %h expected %h", $time, a, e);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = {d1_hs, d1_vs, d1_de, 16'(d1_x), 16'(d1_y), d1_ls, d1_fs, d1_vb, d1_fc};
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL sb_small @%0t: got %h expected %h", $time, a, e);
        end
    end

    // Timing measurements on the first line (default) and first frame (small)
    int nls = 0, lc = 0, lper = -1, hs_off = -1, hs_w = 0, de_w = 0;
    int nfs = 0, fcnt = 0, fper = -1, vbn = 0;
    logic [15:0] fc_seen[$];

    always @(posedge clk) begin
        #3;
        if (nls > 0) lc++;
        if (d0_ls === 1'b1) begin
            if (nls == 1) lper = lc;
            lc = 0;
            nls++;
        end
        if (nls == 1 && d0_hs === 1'b0) begin
            if (hs_off < 0) hs_off = lc;
            hs_w++;
        end
        if (nls == 1 && d0_de === 1'b1) de_w++;

        if (nfs > 0) fcnt++;
        if (d1_fs === 1'b1) begin
            if (nfs == 1) fper = fcnt;
            fcnt = 0;
            nfs++;
            if (fc_seen.size() < 3) fc_seen.push_back(d1_fc);
        end
        if (nfs == 1 && d1_vb === 1'b1) vbn++;
    end

    initial begin
        logic [15:0] fc_want[3];
        if (FC_ON) fc_want = '{16'd0, 16'd1, 16'd2};
        else fc_want = '{16'd0, 16'd0, 16'd0};

        for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 1700; k++) step(1'b1, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 300; k++) step(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
        for (int k = 0; k < 50; k++) step(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        repeat (3) @(negedge clk);

        check("line_period", lper, 800);
        check("hsync_offset", hs_off, 656);
        check("hsync_width", hs_w, 96);
        check("de_width", de_w, 640);
        check("frame_period_small", fper, 140);
        check("vblank_per_frame_small", vbn, 1);
        check("frame_cnt_samples", fc_seen.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (fc_seen.size() > k) check($sformatf("frame_cnt_%0d", k), int'(fc_seen[k]), int'(fc_want[k]));
        end
        check("sb_drained", q0.size() + q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator, the successor to the fixed 640x480 VGA counter. All H/V timing fields, sync polarities and the pixel down-scale factor are parameters. It adds a run-enable with a clean frame-aligned start, registered outputs, and single-cycle line_start, frame_start and vblank_start strobes. It sits between the pixel clock domain and the framebuffer/scan-out logic, which consumes de, px_x and px_y.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync
SCALE_SHIFT, 1, log2 of the pixel replication factor; px = count >> SCALE_SHIFT
CNT_W, 11, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-low (0 = reset)
en  in  1  run enable
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
de  out  1  display enable; high in the visible area
px_x  out  CNT_W  scaled column: h_cnt >> SCALE_SHIFT
px_y  out  CNT_W  scaled row: v_cnt >> SCALE_SHIFT
line_start  out  1  one-cycle strobe at h_cnt == 0
frame_start  out  1  one-cycle strobe at h_cnt == 0, v_cnt == 0
vblank_start  out  1  one-cycle strobe at h_cnt == 0, v_cnt == V_VISIBLE
frame_cnt  out  16  frame counter (see Optional Feature)

Behaviour:
- Derived values: H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (800 at defaults); V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (525 at defaults).
- State machine: IDLE and RUN.
  - Reset enters IDLE with h_cnt = v_cnt = 0.
  - IDLE -> RUN when en = 1. The counters do not advance in the transition cycle.
  - RUN -> IDLE on the first cycle en = 0 is sampled. The counters clear to 0 in that same cycle, so en is not a pause: re-enabling always restarts at the frame top.
- Counting in RUN:
  - h_cnt increments each cycle and wraps from H_TOTAL-1 to 0.
  - On that wrap, v_cnt increments and wraps from V_TOTAL-1 to 0.
- Output registration and latency:
  - All outputs are registered from the current state and counter values, so they have 1-cycle latency.
  - Output at cycle k+1 describes the counter position at cycle k.
- Output decode (RUN):
  - hsync asserted (= HSYNC_POL) when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC; otherwise ~HSYNC_POL.
  - vsync is decoded the same way on v_cnt using V_VISIBLE, V_FRONT, V_SYNC and VSYNC_POL.
  - de = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
  - px_x and px_y are driven every cycle, blanking included. Shifted values are zero-extended to CNT_W.
- Output values in IDLE: hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, de = 0, px_x = px_y = 0, and all strobes 0.
- Reset: every output takes its IDLE value, and frame_cnt = 0, on the clock edge after rst is sampled low.
  - Reset mid-frame aborts the frame immediately.
  - No frame_start is emitted until the next RUN entry.
- First frame_start: emitted on the first RUN cycle's output, one cycle after the IDLE -> RUN edge. Every frame therefore begins with frame_start + line_start together.
- Simultaneous strobes:
  - frame_start implies line_start.
  - vblank_start and frame_start never coincide, provided V_VISIBLE > 0.

Optional Feature:
Macro VGA_FRAME_CNT_EN.
- Defined: frame_cnt is a 16-bit counter. It increments, wrapping 0xFFFF -> 0, on the same cycle frame_start is asserted, except for the first frame after RUN entry. Its value is held while IDLE and cleared only by reset.
- Undefined: frame_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Defaults, rst low for 4 cycles, then rst = 1 and en = 1 -> first frame_start = line_start = 1 at cycle 2 after en is sampled; de = 1 with px_x = 0, px_y = 0 on that same output cycle.
- Defaults, free run -> de high for 640 consecutive cycles per line; hsync low for exactly 96 cycles, starting 656 cycles after line_start; line period 800; frame period 420000 cycles; vsync low for 1600 cycles starting at line 490.
- Defaults -> px_x sequence 0,0,1,1,...,319,319 across the visible line; px_y = 239 on line 479; vblank_start pulses once per frame at line 480.
- Override HSYNC_POL = 1, VSYNC_POL = 1, SCALE_SHIFT = 0 -> sync pulses high; px_x counts 0..639.
- en dropped mid-frame at line 100, then raised 10 cycles later -> outputs go to IDLE values 1 cycle after en = 0 is sampled; restart emits frame_start, with px_y = 0 and px_x = 0.
- With VGA_FRAME_CNT_EN, run 3 full frames, then assert rst -> frame_cnt reads 0, 1, 2 at successive frame_starts, then 0 after reset.
